// File: rtl/sum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sum_feeder
// Description : Sequences operand pairs from a packet stream into a two-input
//               sum block and strobes each returned result with its pair index.
//               Optional result-wait watchdog enabled by SUM_FEEDER_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_feeder #(
    parameter int PACKET_D_WIDTH = 40,
    parameter int NUM_PAIRS      = 10,
    parameter int WDOG_CYCLES    = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,

    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [PACKET_D_WIDTH-1:0] src_data,

    output logic                      in1_valid,
    input  logic                      in1_ready,
    output logic [PACKET_D_WIDTH-1:0] in1_data,

    output logic                      in2_valid,
    input  logic                      in2_ready,
    output logic [PACKET_D_WIDTH-1:0] in2_data,

    input  logic                      out_valid,
    output logic                      out_ready,
    input  logic [PACKET_D_WIDTH-1:0] out_data,

    output logic                      res_valid,
    output logic [PACKET_D_WIDTH-1:0] res_data,
    output logic [7:0]                res_idx,

    output logic                      busy,
    output logic                      done,
    output logic                      timeout
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_load1 = 3'd1;
    localparam logic [2:0] c_send1 = 3'd2;
    localparam logic [2:0] c_load2 = 3'd3;
    localparam logic [2:0] c_send2 = 3'd4;
    localparam logic [2:0] c_wait  = 3'd5;
    localparam logic [2:0] c_emit  = 3'd6;
    localparam logic [2:0] c_done  = 3'd7;

    localparam logic [7:0] c_last_idx = 8'(NUM_PAIRS - 1);

    // res_idx is 8 bits wide, so at most 256 pairs per run are addressable.
    if (NUM_PAIRS < 1 || NUM_PAIRS > 256 || WDOG_CYCLES < 1) begin : g_param_check
        $error("sum_feeder: NUM_PAIRS must be 1..256 and WDOG_CYCLES >= 1");
    end

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic [PACKET_D_WIDTH-1:0] r_op1;
    logic [PACKET_D_WIDTH-1:0] r_op2;
    logic [PACKET_D_WIDTH-1:0] r_result;
    logic [7:0]                r_cnt;

    logic w_start;
    logic w_src_xfer;
    logic w_in1_xfer;
    logic w_in2_xfer;
    logic w_out_xfer;
    logic w_wdog_fire;

    assign w_start    = start & ((r_state == c_idle) | (r_state == c_done));
    assign w_src_xfer = src_valid & src_ready;
    assign w_in1_xfer = in1_valid & in1_ready;
    assign w_in2_xfer = in2_valid & in2_ready;
    assign w_out_xfer = out_valid & out_ready;

`ifdef SUM_FEEDER_WDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic                r_timeout;

    // The counter is zero on the first WAIT cycle because every other state clears it.
    assign w_wdog_fire = (r_state == c_wait) & ~w_out_xfer & (r_wdog == c_wdog_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if ((r_state == c_wait) && !w_out_xfer) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_timeout <= 1'b0;
        end else if (w_wdog_fire) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog_fire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_start) w_next = c_load1;
            c_load1: if (w_src_xfer) w_next = c_send1;
            c_send1: if (w_in1_xfer) w_next = c_load2;
            c_load2: if (w_src_xfer) w_next = c_send2;
            c_send2: if (w_in2_xfer) w_next = c_wait;
            c_wait: begin
                if (w_out_xfer) begin
                    w_next = c_emit;
                end else if (w_wdog_fire) begin
                    w_next = c_done;
                end
            end
            c_emit:  w_next = (r_cnt == c_last_idx) ? c_done : c_load1;
            c_done:  if (w_start) w_next = c_load1;
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        out_ready = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        busy      = (r_state != c_idle) && (r_state != c_done);
        case (r_state)
            c_load1: src_ready = 1'b1;
            c_send1: in1_valid = 1'b1;
            c_load2: src_ready = 1'b1;
            c_send2: in2_valid = 1'b1;
            c_wait:  out_ready = 1'b1;
            c_emit:  res_valid = 1'b1;
            c_done:  done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
        end else begin
            if ((r_state == c_load1) && w_src_xfer) r_op1 <= src_data;
            if ((r_state == c_load2) && w_src_xfer) r_op2 <= src_data;
            if ((r_state == c_wait) && w_out_xfer) r_result <= out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_start) begin
            r_cnt <= 8'd0;
        end else if (r_state == c_emit) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Operand registers only change in LOAD states, so channel data is stable while valid.
    assign in1_data = r_op1;
    assign in2_data = r_op2;
    assign res_data = r_result;
    assign res_idx  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_feeder
// Description : Randomised self-checking bench for sum_feeder with a sum-block
//               model and a pair-level result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_feeder;

    localparam int W  = 40;
    localparam int NP = 2;
    localparam int WD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         src_valid;
    logic         src_ready;
    logic [W-1:0] src_data;
    logic         in1_valid;
    logic         in1_ready;
    logic [W-1:0] in1_data;
    logic         in2_valid;
    logic         in2_ready;
    logic [W-1:0] in2_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic [7:0]   res_idx;
    logic         busy;
    logic         done;
    logic         timeout;

    sum_feeder #(
        .PACKET_D_WIDTH(W),
        .NUM_PAIRS     (NP),
        .WDOG_CYCLES   (WD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data (src_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .in1_data (in1_data),
        .in2_valid(in2_valid),
        .in2_ready(in2_ready),
        .in2_data (in2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_idx  (res_idx),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // environment knobs
    int src_pct, in1_pct, in2_pct, out_pct, sum_mode;
    bit resp_en, force_ov;

    // environment / scoreboard state
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_data[$];
    logic [7:0]   got_idx[$];
    logic [W-1:0] m_a, m_sum, p1, p2;
    bit           m_has, h1, h2;
    int           viol, nsrc;

    function automatic logic [W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Sum block behaviour; mode 1 is asymmetric so swapped operands are visible.
    function automatic logic [W-1:0] sum_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        if (sum_mode == 0) return a + b;
        return (a ^ {b[W-4:0], 3'b000}) + W'(1);
    endfunction

    // Called at a falling edge: observe, drive the next edge's inputs, predict transfers.
    task automatic step();
        if (res_valid) begin
            got_data.push_back(res_data);
            got_idx.push_back(res_idx);
        end
        if (in1_valid && in2_valid) viol++;
        if (h1 && (!in1_valid || in1_data !== p1)) viol++;
        if (h2 && (!in2_valid || in2_data !== p2)) viol++;

        src_valid = (src_q.size() > 0) && (int'($urandom_range(99)) < src_pct);
        src_data  = src_valid ? src_q[0] : rand_word();
        in1_ready = int'($urandom_range(99)) < in1_pct;
        in2_ready = int'($urandom_range(99)) < in2_pct;
        out_valid = force_ov || (m_has && resp_en && (int'($urandom_range(99)) < out_pct));
        out_data  = force_ov ? rand_word() : m_sum;

        if (src_valid && src_ready) begin
            void'(src_q.pop_front());
            nsrc++;
        end
        if (in1_valid && in1_ready) m_a = in1_data;
        if (in2_valid && in2_ready) begin
            m_sum = sum_fn(m_a, in2_data);
            m_has = 1'b1;
        end
        if (out_valid && out_ready && !force_ov) m_has = 1'b0;
        h1 = in1_valid && !in1_ready;
        p1 = in1_data;
        h2 = in2_valid && !in2_ready;
        p2 = in2_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            step();
            n++;
        end
    endtask

    task automatic gen_pairs(input int k);
        logic [W-1:0] a, b;
        for (int i = 0; i < k; i++) begin
            a = rand_word();
            b = rand_word();
            src_q.push_back(a);
            src_q.push_back(b);
            exp_q.push_back(sum_fn(a, b));
        end
    endtask

    task automatic new_run();
        got_data.delete();
        got_idx.delete();
        exp_q.delete();
        src_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, timeout, res_valid, src_ready, in1_valid, in2_valid, out_ready} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, timeout, res_valid, src_ready, in1_valid, in2_valid, out_ready});
        end
        checks++;
        if (in1_data !== '0 || in2_data !== '0 || res_data !== '0 || res_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", in1_data, in2_data, res_data, res_idx);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: got busy=%b src_ready=%b want 0 0", busy, src_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        sum_mode = 0;
        new_run();
        src_q = '{40'd5, 40'd7, 40'd100, 40'd28};
        do_start();
        wait_done(100, n);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL basic_latency: got %0d clocks want 12", n);
        end
        checks++;
        if (got_data.size() !== 2) begin
            errors++;
            $display("FAIL basic_count: got %0d results want 2", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 40'd12 || got_idx[0] !== 8'd0) begin
                errors++;
                $display("FAIL basic_res0: got %0d idx %0d want 12 idx 0", got_data[0], got_idx[0]);
            end
            checks++;
            if (got_data[1] !== 40'd128 || got_idx[1] !== 8'd1) begin
                errors++;
                $display("FAIL basic_res1: got %0d idx %0d want 128 idx 1", got_data[1], got_idx[1]);
            end
        end
        checks++;
        if ({done, busy, src_ready, in1_valid, in2_valid, out_ready, res_valid} !== 7'b1000000) begin
            errors++;
            $display("FAIL basic_done_state: got %b want 1000000",
                     {done, busy, src_ready, in1_valid, in2_valid, out_ready, res_valid});
        end
    endtask

    task automatic test_in1_stall();
        int n, n0;
        logic [W-1:0] op;
        sum_mode = 1;
        new_run();
        gen_pairs(NP);
        op = src_q[0];
        in1_pct = 0;
        do_start();
        n = 0;
        while (!in1_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!in1_valid) begin
            errors++;
            $display("FAIL stall_reach_send1: got in1_valid=%b want 1", in1_valid);
        end
        n0 = nsrc;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (in1_valid !== 1'b1 || in1_data !== op || in2_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v1=%b d1=%h v2=%b want 1 %h 0", i, in1_valid, in1_data, in2_valid, op);
            end
        end
        checks++;
        if (nsrc !== n0) begin
            errors++;
            $display("FAIL stall_no_src: got %0d src transfers want 0", nsrc - n0);
        end
        in1_pct = 100;
        wait_done(200, n);
        checks++;
        if (got_data.size() !== NP || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL stall_results: got %0d results first %h want %0d first %h",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, NP, exp_q[0]);
        end
    endtask

    task automatic test_out_ignore();
        int n;
        sum_mode = 0;
        new_run();
        gen_pairs(NP);
        src_pct = 0;
        do_start();
        checks++;
        if (src_ready !== 1'b1) begin
            errors++;
            $display("FAIL ign_in_load1: got src_ready=%b want 1", src_ready);
        end
        force_ov = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_ready !== 1'b0 || res_valid !== 1'b0 || src_ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ign_cycle%0d: got out_ready=%b res_valid=%b src_ready=%b busy=%b want 0 0 1 1",
                         i, out_ready, res_valid, src_ready, busy);
            end
        end
        force_ov = 1'b0;
        src_pct = 100;
        wait_done(200, n);
        checks++;
        if (got_data.size() !== NP || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1] || got_idx[0] !== 8'd0) begin
            errors++;
            $display("FAIL ign_results: got %0d results first %h want %0d first %h",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, NP, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sum_mode = 1;
        new_run();
        gen_pairs(NP);
        do_start();
        n = 0;
        while (got_data.size() == 0 && n < 50) begin
            step();
            n++;
        end
        in2_pct = 0;
        while (!in2_valid && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!in2_valid || got_data.size() !== 1) begin
            errors++;
            $display("FAIL rmid_reach_send2: got in2_valid=%b results=%0d want 1 1", in2_valid, got_data.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, src_ready, in1_valid, in2_valid, out_ready, res_valid} !== 7'd0 ||
            in1_data !== '0 || in2_data !== '0 || res_data !== '0 || res_idx !== 8'd0) begin
            errors++;
            $display("FAIL rmid_async_clear: got ctl=%b d1=%h d2=%h rd=%h ri=%0d want all zero",
                     {busy, done, src_ready, in1_valid, in2_valid, out_ready, res_valid},
                     in1_data, in2_data, res_data, res_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        h1 = 1'b0;
        h2 = 1'b0;
        m_has = 1'b0;
        in2_pct = 100;
        new_run();
        gen_pairs(NP);
        do_start();
        wait_done(200, n);
        checks++;
        if (got_data.size() !== NP || got_idx[0] !== 8'd0 || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL rmid_rerun: got %0d results first idx %0d want %0d idx 0",
                     got_data.size(), (got_idx.size() > 0) ? got_idx[0] : 8'hff, NP);
        end
    endtask

    task automatic test_wdog();
        int n;
        sum_mode = 0;
        new_run();
        gen_pairs(NP);
        resp_en = 1'b0;
        do_start();
        n = 0;
        while (!out_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!out_ready) begin
            errors++;
            $display("FAIL wdog_reach_wait: got out_ready=%b want 1", out_ready);
        end
`ifdef SUM_FEEDER_WDOG_EN
        wait_done(50, n);
        checks++;
        if (n !== WD || timeout !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL wdog_fire: got %0d clocks timeout=%b done=%b want %0d 1 1", n, timeout, done, WD);
        end
        checks++;
        if (got_data.size() !== 0) begin
            errors++;
            $display("FAIL wdog_no_res: got %0d result strobes want 0", got_data.size());
        end
        m_has = 1'b0;
        resp_en = 1'b1;
`else
        repeat (3 * WD) step();
        checks++;
        if (out_ready !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wdog_absent: got out_ready=%b timeout=%b done=%b want 1 0 0", out_ready, timeout, done);
        end
        resp_en = 1'b1;
        wait_done(200, n);
        checks++;
        if (got_data.size() !== NP || got_data[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL wdog_absent_res: got %0d results want %0d", got_data.size(), NP);
        end
`endif
    endtask

    task automatic test_restart();
        int n;
        sum_mode = 1;
        new_run();
        gen_pairs(NP);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_done: got done=%b want 1", done);
        end
        do_start();
        checks++;
        if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: got done=%b timeout=%b busy=%b want 0 0 1", done, timeout, busy);
        end
        wait_done(200, n);
        checks++;
        if (got_data.size() !== NP || got_idx[0] !== 8'd0 || got_idx[1] !== 8'd1 || got_data[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL restart_idx: got %0d results first idx %0d want %0d idx 0",
                     got_data.size(), (got_idx.size() > 0) ? got_idx[0] : 8'hff, NP);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 8; r++) begin
            sum_mode = r % 2;
            src_pct = int'($urandom_range(100, 30));
            in1_pct = int'($urandom_range(100, 30));
            in2_pct = int'($urandom_range(100, 30));
            out_pct = int'($urandom_range(100, 30));
            new_run();
            gen_pairs(NP);
            do_start();
            wait_done(400, n);
            checks++;
            if (got_data.size() !== NP || !done) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d results done=%b want %0d 1", r, got_data.size(), done, NP);
            end else begin
                for (int k = 0; k < NP; k++) begin
                    checks++;
                    if (got_data[k] !== exp_q[k] || got_idx[k] !== 8'(k)) begin
                        errors++;
                        $display("FAIL rand%0d_res%0d: got %h idx %0d want %h idx %0d",
                                 r, k, got_data[k], got_idx[k], exp_q[k], k);
                    end
                end
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol: got %0d handshake violations want 0", viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        src_valid = 1'b0;
        src_data = '0;
        in1_ready = 1'b0;
        in2_ready = 1'b0;
        out_valid = 1'b0;
        out_data = '0;
        src_pct = 100;
        in1_pct = 100;
        in2_pct = 100;
        out_pct = 100;
        sum_mode = 0;
        resp_en = 1'b1;
        force_ov = 1'b0;
        m_a = '0;
        m_sum = '0;
        p1 = '0;
        p2 = '0;
        m_has = 1'b0;
        h1 = 1'b0;
        h2 = 1'b0;
        viol = 0;
        nsrc = 0;

        test_reset();
        test_basic();
        test_in1_stall();
        test_out_ignore();
        test_reset_mid();
        test_wdog();
        test_restart();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
